// File: rtl/miner_work_scheduler.sv
// miner_work_scheduler: latches work, issues one nonce per step to the hashers,
// matches pipeline outputs to their nonces and queues golden nonces in a FWFT FIFO.
// Optional feature macro SHARE_TARGET_EN: adds share_target and hits on hash_h7 <= share_target.
module miner_work_scheduler #(
    parameter int LOOP_LOG2       = 0,
    parameter int NONCE_OFFSET    = 136,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         work_valid,
    input  logic [255:0] work_midstate,
    input  logic [95:0]  work_data,
    input  logic [31:0]  work_nonce,
    output logic         work_req,
    output logic [255:0] midstate_buf,
    output logic [95:0]  data_buf,
    output logic [31:0]  nonce,
    output logic         hash_en,
    input  logic [31:0]  hash_h7,
`ifdef SHARE_TARGET_EN
    input  logic [31:0]  share_target,
`endif
    output logic         golden_valid,
    output logic [31:0]  golden_nonce,
    input  logic         golden_ready,
    output logic         overflow
);
    localparam int PW = (LOOP_LOG2 > 0) ? LOOP_LOG2 : 1;
    localparam int WW = $clog2(NONCE_OFFSET + 1);
    localparam int AW = FIFO_DEPTH_LOG2;
    localparam int CW = FIFO_DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [PW-1:0] PHASE_LAST = PW'((1 << LOOP_LOG2) - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  phase_q, phase_d;
    logic [WW-1:0]  warm_q, warm_d;
    logic [31:0]    nonce_q, nonce_d, check_q, check_d;
    logic [255:0]   midstate_q, midstate_d;
    logic [95:0]    data_q, data_d;
    logic [31:0]    mem_q [DEPTH];
    logic [AW-1:0]  wr_q, rd_q;
    logic [CW-1:0]  cnt_q;
    logic           overflow_q;
    logic           active, boundary, hit, check_en, push, pop, full, wr_en;

    assign active   = state_q != IDLE;
    assign boundary = active && phase_q == PHASE_LAST;
`ifdef SHARE_TARGET_EN
    assign hit      = hash_h7 <= share_target;
`else
    assign hit      = hash_h7 == 32'd0;
`endif
    assign check_en = boundary && warm_q == '0;
    // A reload discards whatever the old job would have reported this cycle.
    assign push     = check_en && hit && !work_valid;
    assign pop      = cnt_q != '0 && golden_ready;
    assign full     = cnt_q == CW'(DEPTH);
    assign wr_en    = push && (!full || pop);

    assign work_req     = state_q == IDLE;
    assign hash_en      = active;
    assign midstate_buf = midstate_q;
    assign data_buf     = data_q;
    assign nonce        = nonce_q;
    assign golden_valid = cnt_q != '0;
    assign golden_nonce = golden_valid ? mem_q[rd_q] : 32'd0;
    assign overflow     = overflow_q;

    // Next-state: work load has priority; otherwise advance issue/check at step boundaries.
    always_comb begin
        state_d    = state_q;
        phase_d    = active ? (boundary ? '0 : phase_q + PW'(1)) : phase_q;
        warm_d     = warm_q;
        nonce_d    = nonce_q;
        check_d    = check_q;
        midstate_d = midstate_q;
        data_d     = data_q;
        if (work_valid) begin
            state_d    = RUN;
            phase_d    = '0;
            warm_d     = WW'(NONCE_OFFSET);
            nonce_d    = work_nonce;
            check_d    = work_nonce;
            midstate_d = work_midstate;
            data_d     = work_data;
        end else if (boundary) begin
            if (warm_q != '0) warm_d = warm_q - WW'(1);
            if (state_q == RUN) begin
                if (nonce_q == 32'hFFFF_FFFF) state_d = DRAIN;
                else nonce_d = nonce_q + 32'd1;
            end
            if (check_en) begin
                check_d = check_q + 32'd1;
                if (state_q == DRAIN && check_q == 32'hFFFF_FFFF) state_d = IDLE;
            end
        end
    end

    // Scheduler state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            warm_q     <= '0;
            nonce_q    <= '0;
            check_q    <= '0;
            midstate_q <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            warm_q     <= warm_d;
            nonce_q    <= nonce_d;
            check_q    <= check_d;
            midstate_q <= midstate_d;
            data_q     <= data_d;
        end
    end

    // Golden FIFO storage; contents are only visible while the count is non-zero.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q] <= check_q;
    end

    // Golden FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) wr_q <= wr_q + AW'(1);
            if (pop) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + CW'(wr_en) - CW'(pop);
            if (work_valid) overflow_q <= 1'b0;
            else if (push && full && !pop) overflow_q <= 1'b1;
        end
    end
endmodule
